// File: rtl/cplx_dot_engine.sv
// cplx_dot_engine: streaming complex fixed-point dot-product engine.
// Accepts LANES complex element pairs per beat. It accumulates
// sum(a_k*b_k) across beats until a last marker, then emits one rounded,
// saturated Q(FRAC_BITS) complex result on a valid/ready output.
// Ports:
//   src_clk, rst        clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake; in_last closes the vector
//   a_/b_real/imag      LANES packed lanes, lane k at [k*WORD_LEN +: WORD_LEN]
//   out_valid/out_ready result handshake
//   out_real/out_imag   rounded, saturated result; out_sat flags a clip
//   busy                pipeline holds data or a vector is open
module cplx_dot_engine #(
  parameter int unsigned WORD_LEN  = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_GUARD = 8
) (
  input  logic                        src_clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [WORD_LEN*LANES-1:0]   a_real,
  input  logic [WORD_LEN*LANES-1:0]   a_imag,
  input  logic [WORD_LEN*LANES-1:0]   b_real,
  input  logic [WORD_LEN*LANES-1:0]   b_imag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_LEN-1:0]         out_real,
  output logic [WORD_LEN-1:0]         out_imag,
  output logic                        out_sat,
  output logic                        busy
);

  localparam int unsigned LG = $clog2(LANES);
  localparam int unsigned VW = WORD_LEN * LANES;
  localparam int unsigned PW = 2 * WORD_LEN + 1;
  localparam int unsigned SW = PW + LG;
  localparam int unsigned AW = SW + ACC_GUARD;
  localparam int unsigned RW = AW + 1;

  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-WORD_LEN+1){1'b0}}, {(WORD_LEN-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [RW-1:0] RND     = RW'(1) << (FRAC_BITS - 1);

  // Sign-extended lane operand.
  function automatic logic signed [PW-1:0] lane(input logic [VW-1:0] v, input int k);
    lane = PW'(signed'(v[k*WORD_LEN +: WORD_LEN]));
  endfunction

  // Returns {clip, value} after saturating to WORD_LEN signed.
  function automatic logic [WORD_LEN:0] sat(input logic signed [RW-1:0] x);
    if (x > SAT_MAX)      sat = {2'b10, {(WORD_LEN-1){1'b1}}};
    else if (x < SAT_MIN) sat = {2'b11, {(WORD_LEN-1){1'b0}}};
    else                  sat = {1'b0, x[WORD_LEN-1:0]};
  endfunction

  // Pipeline state
  logic                 s0_vld, s0_last, s1_vld, s1_last, s2_vld, s2_last;
  logic [VW-1:0]        s0_ar, s0_ai, s0_br, s0_bi;
  logic signed [PW-1:0] s1_re [LANES];
  logic signed [PW-1:0] s1_im [LANES];
  logic signed [SW-1:0] s2_re, s2_im;
  logic signed [AW-1:0] acc_re, acc_im;
  logic                 first, open;

  // Combinational next values
  logic                 stall, accept, land, land_last;
  logic                 s0_vld_n, s1_vld_n, s2_vld_n, open_n, busy_n, out_valid_n;
  logic signed [PW-1:0] prod_re [LANES];
  logic signed [PW-1:0] prod_im [LANES];
  logic signed [SW-1:0] sum_re, sum_im;
  logic signed [AW-1:0] acc_re_n, acc_im_n;
  logic signed [RW-1:0] sh_re, sh_im;
  logic [WORD_LEN:0]    sat_re, sat_im;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && !rst;
  assign accept   = in_valid && in_ready;
  assign land      = s2_vld && !stall;
  assign land_last = land && s2_last;

  // Lane products and tree sum, full precision
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      prod_re[k] = lane(s0_ar, k) * lane(s0_br, k) - lane(s0_ai, k) * lane(s0_bi, k);
      prod_im[k] = lane(s0_ar, k) * lane(s0_bi, k) + lane(s0_ai, k) * lane(s0_br, k);
      sum_re = sum_re + SW'(s1_re[k]);
      sum_im = sum_im + SW'(s1_im[k]);
    end
  end

  // Accumulate, round half up, shift, saturate
  always_comb begin
    acc_re_n = first ? AW'(s2_re) : acc_re + AW'(s2_re);
    acc_im_n = first ? AW'(s2_im) : acc_im + AW'(s2_im);
    sh_re    = (RW'(acc_re_n) + RND) >>> FRAC_BITS;
    sh_im    = (RW'(acc_im_n) + RND) >>> FRAC_BITS;
    sat_re   = sat(sh_re);
    sat_im   = sat(sh_im);
  end

  // Control next state
  always_comb begin
    s0_vld_n    = s0_vld;
    s1_vld_n    = s1_vld;
    s2_vld_n    = s2_vld;
    open_n      = open;
    out_valid_n = out_valid;
    if (!stall) begin
      s0_vld_n = accept;
      s1_vld_n = s0_vld;
      s2_vld_n = s1_vld;
    end
    if (accept) open_n = !in_last;
    if (land_last) out_valid_n = 1'b1;
    else if (out_valid && out_ready) out_valid_n = 1'b0;
    busy_n = s0_vld_n || s1_vld_n || s2_vld_n || open_n;
  end

  // Control and output registers
  always_ff @(posedge src_clk) begin
    if (rst) begin
      s0_vld    <= 1'b0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      open      <= 1'b0;
      first     <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_sat   <= 1'b0;
    end else begin
      s0_vld    <= s0_vld_n;
      s1_vld    <= s1_vld_n;
      s2_vld    <= s2_vld_n;
      open      <= open_n;
      busy      <= busy_n;
      out_valid <= out_valid_n;
      if (land) first <= s2_last;
      if (land_last) begin
        out_real <= sat_re[WORD_LEN-1:0];
        out_imag <= sat_im[WORD_LEN-1:0];
        out_sat  <= sat_re[WORD_LEN] | sat_im[WORD_LEN];
      end
    end
  end

  // Datapath registers; qualified by the valid bits above
  always_ff @(posedge src_clk) begin
    if (!stall) begin
      s0_ar   <= a_real;
      s0_ai   <= a_imag;
      s0_br   <= b_real;
      s0_bi   <= b_imag;
      s0_last <= in_last;
      s1_re   <= prod_re;
      s1_im   <= prod_im;
      s1_last <= s0_last;
      s2_re   <= sum_re;
      s2_im   <= sum_im;
      s2_last <= s1_last;
    end
    if (land) begin
      acc_re <= acc_re_n;
      acc_im <= acc_im_n;
    end
  end

endmodule
